// File: rtl/enigma_ctrl.sv
// Frame sequencer for the enigma rotor/reflector datapath: steers table loads,
// then issues characters as encrypts and registers each result out.
module enigma_ctrl #(
    parameter int unsigned NUM_TABLES  = 3,
    parameter int unsigned TABLE_DEPTH = 64,
    parameter int unsigned CODE_W      = 6
) (
    input  logic              clk,
    input  logic              srst_n,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_last,
    input  logic [CODE_W-1:0] dp_result,
    output logic              load,
    output logic [1:0]        table_idx,
    output logic [CODE_W-1:0] code_in,
    output logic              encrypt,
    output logic [1:0]        shift_amount,
    output logic              dp_rst_n,
    output logic              out_valid,
    output logic [CODE_W-1:0] out_code,
    output logic              frame_done,
    output logic              frame_err,
    output logic              busy
);

    localparam logic [CODE_W-1:0] LastEnt = CODE_W'(TABLE_DEPTH - 1);
    localparam logic [1:0]        LastTbl = 2'(NUM_TABLES - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StCrypt, StFlush} state_e;

    state_e            state_q;
    logic [CODE_W-1:0] ent_cnt_q;
    logic [1:0]        tbl_cnt_q;

    // The IDLE entry beat is loaded in the same cycle it arrives; in_last during
    // LOAD is a protocol error and the beat is discarded.
    always_comb begin
        load    = 1'b0;
        encrypt = 1'b0;
        case (state_q)
            StIdle:  load    = in_valid;
            StLoad:  load    = in_valid & ~in_last;
            StCrypt: encrypt = in_valid;
            default: ;
        endcase
        code_in      = (load | encrypt) ? in_code : '0;
        shift_amount = encrypt ? dp_result[1:0] : 2'b00;
    end

    assign table_idx = tbl_cnt_q;
    assign busy      = (state_q != StIdle);

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state_q    <= StIdle;
            ent_cnt_q  <= '0;
            tbl_cnt_q  <= '0;
            out_valid  <= 1'b0;
            out_code   <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            dp_rst_n   <= 1'b1;
        end else begin
            out_valid  <= encrypt;
            frame_done <= encrypt & in_last;
            frame_err  <= 1'b0;
            dp_rst_n   <= 1'b1;
            if (encrypt) begin
                out_code <= dp_result;
            end
            case (state_q)
                StIdle, StLoad: begin
                    if (state_q == StLoad && in_valid && in_last) begin
                        frame_err <= 1'b1;
                        dp_rst_n  <= 1'b0;
                        state_q   <= StFlush;
                    end else if (load) begin
                        state_q <= StLoad;
                        if (ent_cnt_q == LastEnt) begin
                            ent_cnt_q <= '0;
                            // tbl_cnt stays on the last table so table_idx holds in CRYPT
                            if (tbl_cnt_q == LastTbl) begin
                                state_q <= StCrypt;
                            end else begin
                                tbl_cnt_q <= tbl_cnt_q + 2'd1;
                            end
                        end else begin
                            ent_cnt_q <= ent_cnt_q + 1'b1;
                        end
                    end
                end
                StCrypt: begin
                    if (encrypt && in_last) begin
                        dp_rst_n <= 1'b0;
                        state_q  <= StFlush;
                    end
                end
                StFlush: begin
                    ent_cnt_q <= '0;
                    tbl_cnt_q <= '0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_enigma_ctrl.sv
// Self-checking bench for enigma_ctrl: directed and randomized frames checked
// against a beat-counting model of the frame protocol.
module tb_enigma_ctrl;

    localparam int NT    = 3;
    localparam int TD    = 64;
    localparam int CW    = 6;
    localparam int TOTAL = NT * TD;

    logic          clk      = 1'b0;
    logic          srst_n   = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_last  = 1'b0;
    logic [CW-1:0] in_code  = '0;
    logic [CW-1:0] key      = '0;
    logic [CW-1:0] dp_result;
    logic          load, encrypt, dp_rst_n, out_valid, frame_done, frame_err, busy;
    logic [1:0]    table_idx, shift_amount;
    logic [CW-1:0] code_in, out_code;

    int checks = 0;
    int errors = 0;

    // Model: count of accepted table entries, frame-active flag, flush-pending flag.
    int m_loaded = 0;
    bit m_active = 1'b0;
    bit m_flush  = 1'b0;

    always #5 clk = ~clk;

    // Datapath stub: result is the driven code offset by a per-frame key.
    assign dp_result = code_in + key;

    enigma_ctrl #(.NUM_TABLES(NT), .TABLE_DEPTH(TD), .CODE_W(CW)) dut (
        .clk          (clk),
        .srst_n       (srst_n),
        .in_valid     (in_valid),
        .in_code      (in_code),
        .in_last      (in_last),
        .dp_result    (dp_result),
        .load         (load),
        .table_idx    (table_idx),
        .code_in      (code_in),
        .encrypt      (encrypt),
        .shift_amount (shift_amount),
        .dp_rst_n     (dp_rst_n),
        .out_valid    (out_valid),
        .out_code     (out_code),
        .frame_done   (frame_done),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_load", load, 0);
        chk("rst_encrypt", encrypt, 0);
        chk("rst_code_in", code_in, 0);
        chk("rst_shift", shift_amount, 0);
        chk("rst_table_idx", table_idx, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_code", out_code, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_dp_rst_n", dp_rst_n, 1);
        chk("rst_busy", busy, 0);
    endtask

    // One clock cycle: drive, check combinational outputs, clock, check registered ones.
    task automatic beat(input bit v, input int code, input bit last);
        bit loading, crypt, exp_load, exp_enc, exp_err, exp_done;
        int exp_out;
        in_valid = v;
        in_code  = CW'(code);
        in_last  = last;
        #1;
        loading  = !m_flush && (!m_active || m_loaded < TOTAL);
        crypt    = !m_flush && m_active && m_loaded == TOTAL;
        exp_load = loading && v && !(m_active && last);
        exp_enc  = crypt && v;
        exp_err  = loading && m_active && v && last;
        exp_done = exp_enc && last;
        exp_out  = (code + int'(key)) % TD;
        chk("load", load, exp_load);
        chk("encrypt", encrypt, exp_enc);
        chk("code_in", code_in, (exp_load || exp_enc) ? code : 0);
        chk("shift_amount", shift_amount, exp_enc ? exp_out % 4 : 0);
        if (!m_flush) chk("table_idx", table_idx, crypt ? NT - 1 : m_loaded / TD);
        @(posedge clk);
        #1;
        if (m_flush) begin
            m_flush  = 1'b0;
            m_active = 1'b0;
            m_loaded = 0;
        end else if (exp_load) begin
            m_active = 1'b1;
            m_loaded++;
        end else if (exp_err || exp_done) begin
            m_flush = 1'b1;
        end
        chk("out_valid", out_valid, exp_enc);
        if (exp_enc) chk("out_code", out_code, exp_out);
        chk("frame_done", frame_done, exp_done);
        chk("frame_err", frame_err, exp_err);
        chk("dp_rst_n", dp_rst_n, !m_flush);
        chk("busy", busy, m_active || m_flush);
    endtask

    task automatic load_frame(input int gap_pct, input bit rnd_codes);
        for (int i = 0; i < TOTAL; i++) begin
            while (int'($urandom_range(99)) < gap_pct) beat(1'b0, int'($urandom_range(63)), 1'b0);
            beat(1'b1, rnd_codes ? int'($urandom_range(63)) : i % TD, 1'b0);
        end
    endtask

    task automatic chars(input int n, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(99)) < gap_pct) beat(1'b0, 0, 1'b0);
            beat(1'b1, int'($urandom_range(63)), i == n - 1);
        end
        beat(1'b0, 0, 1'b0);
        beat(1'b0, 0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle.
        #2 srst_n = 1'b0;
        #1 check_reset_outputs();
        @(negedge clk);
        srst_n = 1'b1;
        for (int i = 0; i < 10; i++) beat(1'b0, 0, 1'b0);

        // Contiguous load of i mod 64, then directed characters with result = code + 1.
        key = 6'd1;
        load_frame(0, 1'b0);
        beat(1'b1, 5, 1'b0);
        beat(1'b1, 9, 1'b0);
        beat(1'b1, 63, 1'b1);
        beat(1'b0, 0, 1'b0);
        beat(1'b0, 0, 1'b0);

        // Gapped load and gapped characters with a random key.
        key = CW'($urandom_range(63));
        load_frame(30, 1'b1);
        chars(20, 30);

        // in_last on load beat 100 aborts the frame; the next frame starts at table 0.
        for (int i = 0; i < 100; i++) beat(1'b1, int'($urandom_range(63)), 1'b0);
        beat(1'b1, 7, 1'b1);
        beat(1'b0, 0, 1'b0);
        beat(1'b0, 0, 1'b0);
        key = CW'($urandom_range(63));
        load_frame(20, 1'b1);
        chars(8, 20);

        // Asynchronous reset mid-CRYPT, between clock edges.
        load_frame(0, 1'b1);
        beat(1'b1, int'($urandom_range(63)), 1'b0);
        beat(1'b1, int'($urandom_range(63)), 1'b0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        #2 srst_n = 1'b0;
        #1 check_reset_outputs();
        m_loaded = 0;
        m_active = 1'b0;
        m_flush  = 1'b0;
        @(negedge clk);
        srst_n = 1'b1;
        key = CW'($urandom_range(63));
        load_frame(10, 1'b1);
        chars(6, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/enigma_ctrl.md
Name: enigma_ctrl

Overview:
- Frame sequencer for the rotor/reflector datapath (rotor A, rotor B, reflector) of the enigma machine.
- Takes one input stream. The first NUM_TABLES*TABLE_DEPTH beats are table entries and are steered into the datapath as loads. Every later beat is a plaintext/ciphertext character, issued as an encrypt.
- Derives the rotor shift amount from each result, registers the result out, and re-arms the datapath between frames.

Parameters:
- NUM_TABLES, 3, number of tables loaded per frame; table_idx counts 0..NUM_TABLES-1.
- TABLE_DEPTH, 64, entries per table; must be 2**CODE_W.
- CODE_W, 6, code width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- srst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  a beat is present on in_code this cycle.
- in_code  input  CODE_W  table entry or character.
- in_last  input  1  qualifies the final character of the frame; valid only with in_valid.
- dp_result  input  CODE_W  combinational datapath result for the current code_in.
- load  output  1  datapath load strobe.
- table_idx  output  2  table currently being loaded.
- code_in  output  CODE_W  code driven to the datapath.
- encrypt  output  1  datapath encrypt strobe.
- shift_amount  output  2  rotor A shift applied at this edge.
- dp_rst_n  output  1  active-low datapath re-arm; clears its load counters and tables.
- out_valid  output  1  out_code holds a result.
- out_code  output  CODE_W  registered result.
- frame_done  output  1  one-cycle pulse coinciding with the last out_valid.
- frame_err  output  1  one-cycle pulse on a protocol error.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, srst_n=0):
  - state=IDLE, ent_cnt=0, tbl_cnt=0.
  - All registered outputs are 0, except dp_rst_n=1.
  - Combinational outputs load=encrypt=shift_amount=0 follow from IDLE.
  - Reset mid-frame abandons the frame. The datapath is only cleared by its own reset, so the bench must reset both together.
- States: IDLE, LOAD, CRYPT, FLUSH.
- IDLE:
  - in_valid=1 moves to LOAD, and this same beat is entry 0 of table 0. load=1 is asserted combinationally in this cycle.
  - in_valid=0 keeps IDLE.
- LOAD:
  - load = in_valid & (state==LOAD, or the IDLE entry beat); code_in=in_code; table_idx=tbl_cnt.
  - Each accepted beat increments ent_cnt.
  - At ent_cnt==TABLE_DEPTH-1: ent_cnt wraps to 0 and tbl_cnt increments.
  - At the last entry of table NUM_TABLES-1: go to CRYPT.
  - in_valid=0 stalls; no counter changes.
  - in_last=1 with in_valid in LOAD: beat discarded (load=0), frame_err pulses next cycle, go to FLUSH.
- CRYPT:
  - encrypt=in_valid; code_in=in_code.
  - shift_amount = encrypt ? dp_result[1:0] : 0, combinational; the datapath rotates at the same edge.
  - Next cycle: out_valid=1, out_code=registered dp_result (latency 1).
  - Beat with in_last=1: frame_done pulses with its out_valid, then go to FLUSH.
  - No beat: out_valid=0 next cycle.
- FLUSH:
  - Exactly one cycle with dp_rst_n=0; in_valid is ignored (dropped, not stalled) and counters clear.
  - Then IDLE.
- code_in is 0 whenever neither load nor encrypt is asserted.
- No backpressure: the upstream source must not present beats in FLUSH; frame_err does not fire for such beats.
- load and encrypt are never high together; table_idx is held at NUM_TABLES-1 during CRYPT.

Test Plan:
- Reset with in_valid=0 → all outputs 0, dp_rst_n=1, busy=0, state IDLE for 10 cycles.
- 192 contiguous load beats with value i mod 64 → load high 192 cycles; table_idx=0 for beats 0-63, 1 for 64-127, 2 for 128-191; state CRYPT after beat 191; encrypt never high.
- Load frame, then chars 5, 9, 63 (last) with dp_result stubbed as code+1 → shift_amount=2, 2, 0; out_code=6, 10, 0 on cycles +1; frame_done with the third out_valid; dp_rst_n low exactly one cycle after; then IDLE.
- in_valid toggling 1,0,1 during both LOAD and CRYPT → counters, load and encrypt freeze on 0 cycles; out_valid=0 following each gap; total accepted entries still exactly 192.
- in_last asserted at load beat 100 → that beat not loaded; frame_err pulse; dp_rst_n low one cycle; busy=0 two cycles later; next frame loads from table 0 entry 0.
- srst_n driven low mid-CRYPT between clock edges → outputs clear immediately without a clock edge, busy=0; a new 192-beat load completes normally after release.
